// File: rtl/googletest_hdl_pkg.sv
// Shared types for the googletest HDL bench helpers.
package googletest_hdl_pkg;

  localparam int OBJCTL_STATE_W = 2;

  // End-of-test controller phases; the encoding is visible on the debug state port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } objctl_state_e;

endpackage

// File: rtl/googletest_objection_counter.sv
// One requester's objection count: saturating up/down counter with sticky
// underflow/overflow flags. A flag raised in the same cycle as i_clr_err survives,
// so an error that coincides with the start of a run is still reported.
module googletest_objection_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr_err,
  input  logic             i_raise,
  input  logic             i_drop,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_underflow,
  output logic             o_overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_underflow;
  logic             r_overflow;
  logic             w_inc;
  logic             w_dec;
  logic             w_set_ovf;
  logic             w_set_unf;

  // raise and drop together cancel out
  assign w_inc     = i_raise & ~i_drop;
  assign w_dec     = i_drop & ~i_raise;
  assign w_set_ovf = w_inc & (r_cnt == CNT_MAX);
  assign w_set_unf = w_dec & (r_cnt == '0);

  // Count update with saturation at both ends, plus sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_inc && !w_set_ovf) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_dec && !w_set_unf) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      r_underflow <= (r_underflow & ~i_clr_err) | w_set_unf;
      r_overflow  <= (r_overflow & ~i_clr_err) | w_set_ovf;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_underflow = r_underflow;
  assign o_overflow  = r_overflow;

endmodule

// File: rtl/googletest_objection_ctrl.sv
// End-of-test controller: collects raise/drop objections from bench agents,
// waits for a sustained quiet period (drain) and reports done, or timeout when
// the watchdog expires first.
// Interface semantics: start, raise and drop are single-cycle pulses sampled on
// the rising edge; there is no back-pressure. done/timeout are levels held in DONE.
module googletest_objection_ctrl
  import googletest_hdl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CNT_W        = 8,
  parameter int DRAIN_CYCLES = 16,
  parameter int WDOG_W       = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [NUM_REQ-1:0]              raise,
  input  logic [NUM_REQ-1:0]              drop,
  input  logic [WDOG_W-1:0]               wdog_limit,
  output logic [CNT_W+$clog2(NUM_REQ):0]  total,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout,
  output logic [NUM_REQ-1:0]              underflow_err,
  output logic [NUM_REQ-1:0]              overflow_err,
  output logic [OBJCTL_STATE_W-1:0]       state
);

  localparam int TOT_W   = CNT_W + $clog2(NUM_REQ) + 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  objctl_state_e                 r_state;
  objctl_state_e                 w_state_nxt;
  logic [DRAIN_W-1:0]            r_drain_cnt;
  logic [WDOG_W-1:0]             r_wdog_cnt;
  logic                          r_timeout;
  logic [NUM_REQ-1:0][CNT_W-1:0] w_cnt;
  logic [NUM_REQ-1:0]            w_underflow;
  logic [NUM_REQ-1:0]            w_overflow;
  logic [TOT_W-1:0]              w_total;
  logic                          w_quiet;
  logic                          w_start_run;
  logic                          w_wdog_exp;
  logic                          w_drain_last;
  logic                          w_busy;
  logic                          w_done;

  // One counter per requester; error flags clear when a run is accepted
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    googletest_objection_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr_err   (w_start_run),
      .i_raise     (raise[g]),
      .i_drop      (drop[g]),
      .o_cnt       (w_cnt[g]),
      .o_underflow (w_underflow[g]),
      .o_overflow  (w_overflow[g])
    );
  end

  // Sum of all registered counts; widened so NUM_REQ saturated counters cannot wrap
  always_comb begin
    w_total = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_total = w_total + TOT_W'(w_cnt[i]);
    end
  end

  // A raise in the current cycle breaks quiet even before it reaches the counters
  assign w_quiet      = (w_total == '0) && (raise == '0);
  assign w_start_run  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_wdog_exp   = (wdog_limit != '0) && (r_wdog_cnt == wdog_limit - WDOG_W'(1));
  assign w_drain_last = (r_drain_cnt == DRAIN_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: watchdog expiry outranks drain completion
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_wdog_exp)   w_state_nxt = DONE;
        else if (w_quiet) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_wdog_exp)        w_state_nxt = DONE;
        else if (!w_quiet)     w_state_nxt = RUN;
        else if (w_drain_last) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      RUN, DRAIN: w_busy = 1'b1;
      DONE:       w_done = 1'b1;
      default:    ;
    endcase
  end

  // Watchdog, timeout flag and drain counter; drain restarts at 0 whenever RUN is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      if (w_start_run) begin
        r_wdog_cnt <= '0;
        r_timeout  <= 1'b0;
      end else if (w_busy) begin
        r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
        if (w_wdog_exp) r_timeout <= 1'b1;
      end
      if (r_state == RUN) begin
        r_drain_cnt <= '0;
      end else if ((r_state == DRAIN) && w_quiet) begin
        r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
      end
    end
  end

  assign total         = w_total;
  assign busy          = w_busy;
  assign done          = w_done;
  assign timeout       = r_timeout;
  assign underflow_err = w_underflow;
  assign overflow_err  = w_overflow;
  assign state         = r_state;

endmodule

// File: tb/tb_googletest_objection_ctrl.sv
// Bench for googletest_objection_ctrl: directed scenarios plus random objection
// traffic, every cycle compared against a behavioural model of the run rules.
module tb_googletest_objection_ctrl;

  localparam int NUM_REQ      = 4;
  localparam int CNT_W        = 2;
  localparam int DRAIN_CYCLES = 4;
  localparam int WDOG_W       = 16;
  localparam int TOT_W        = CNT_W + $clog2(NUM_REQ) + 1;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
  localparam int P_IDLE = 0, P_BUSY = 1, P_DONE = 2;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [NUM_REQ-1:0]   raise = '0;
  logic [NUM_REQ-1:0]   drop = '0;
  logic [WDOG_W-1:0]    wdog_limit = '0;
  logic [TOT_W-1:0]     total;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic [NUM_REQ-1:0]   underflow_err;
  logic [NUM_REQ-1:0]   overflow_err;
  logic [1:0]           state;

  always #5 clk = ~clk;

  googletest_objection_ctrl #(
    .NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN_CYCLES), .WDOG_W(WDOG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .raise(raise), .drop(drop),
    .wdog_limit(wdog_limit), .total(total), .busy(busy), .done(done),
    .timeout(timeout), .underflow_err(underflow_err), .overflow_err(overflow_err),
    .state(state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A run is "busy" from start until either DRAIN_CYCLES+1 consecutive quiet
  // busy cycles have elapsed or the watchdog limit of busy cycles is reached.
  int m_cnt [NUM_REQ];
  bit m_unf [NUM_REQ];
  bit m_ovf [NUM_REQ];
  int m_phase;
  int m_elapsed;
  int m_streak;
  bit m_timeout;

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      m_cnt[i] = 0; m_unf[i] = 0; m_ovf[i] = 0;
    end
    m_phase = P_IDLE; m_elapsed = 0; m_streak = 0; m_timeout = 0;
  endtask

  task automatic model_step();
    int sum;
    bit quiet;
    sum = 0;
    for (int i = 0; i < NUM_REQ; i++) sum += m_cnt[i];
    quiet = (sum == 0) && (raise == '0);
    if (m_phase == P_BUSY) begin
      m_elapsed++;
      m_streak = quiet ? m_streak + 1 : 0;
      if (wdog_limit != 0 && m_elapsed == int'(wdog_limit)) begin
        m_phase = P_DONE; m_timeout = 1;
      end else if (m_streak == DRAIN_CYCLES + 1) begin
        m_phase = P_DONE;
      end
    end else if (start) begin
      m_phase = P_BUSY; m_elapsed = 0; m_streak = 0; m_timeout = 0;
      for (int i = 0; i < NUM_REQ; i++) begin m_unf[i] = 0; m_ovf[i] = 0; end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (raise[i] && !drop[i]) begin
        if (m_cnt[i] == CNT_MAX) m_ovf[i] = 1; else m_cnt[i]++;
      end else if (drop[i] && !raise[i]) begin
        if (m_cnt[i] == 0) m_unf[i] = 1; else m_cnt[i]--;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  function automatic int exp_state();
    if (m_phase == P_IDLE) return 0;
    if (m_phase == P_DONE) return 3;
    return (m_streak == 0) ? 1 : 2;
  endfunction

  task automatic check_all();
    int sum;
    logic [NUM_REQ-1:0] eu, eo;
    sum = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum += m_cnt[i]; eu[i] = m_unf[i]; eo[i] = m_ovf[i];
    end
    check("state", 32'(state), exp_state());
    check("busy", 32'(busy), 32'(m_phase == P_BUSY));
    check("done", 32'(done), 32'(m_phase == P_DONE));
    check("timeout", 32'(timeout), 32'(m_timeout));
    check("total", 32'(total), sum);
    check("underflow_err", 32'(underflow_err), 32'(eu));
    check("overflow_err", 32'(overflow_err), 32'(eo));
    check("done_busy_excl", 32'(done & busy), 0);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive one cycle of inputs, then check after the next rise.
  task automatic cycle(input logic st, input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] d);
    start = st; raise = r; drop = d;
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until_done(input int budget, output int nbusy);
    nbusy = 0;
    for (int k = 0; k < budget && !done; k++) begin
      if (busy) nbusy++;
      cycle(1'b0, '0, '0);
    end
    check("reach_done", 32'(done), 1);
  endtask

  // Assert reset between edges and check the asynchronous clear before any clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_all();
    check("rst_state", 32'(state), 0);
    check("rst_total", 32'(total), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb;
    logic [NUM_REQ-1:0] r, d;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    check("reset_state", 32'(state), 0);
    rst_n = 1'b1;
    cycle(1'b0, '0, '0);

    // Empty run
    cycle(1'b1, '0, '0);
    run_until_done(50, nb);
    check("empty_busy_cycles", nb, DRAIN_CYCLES + 1);
    check("empty_timeout", 32'(timeout), 0);

    // Normal run: counts build to 3, then drain away
    cycle(1'b1, 4'b0001, '0);
    cycle(1'b0, 4'b0001, '0);
    cycle(1'b0, 4'b0100, '0);
    check("normal_total_peak", 32'(total), 3);
    for (int k = 0; k < 20; k++) begin
      d = (k == 5) ? 4'b0001 : (k == 11) ? 4'b0100 : (k == 17) ? 4'b0001 : 4'b0000;
      cycle(1'b0, '0, d);
    end
    run_until_done(50, nb);

    // Drain interrupt on the last drain cycle
    cycle(1'b1, '0, '0);
    repeat (DRAIN_CYCLES) cycle(1'b0, '0, '0);
    check("intr_last_drain", 32'(state), 2);
    cycle(1'b0, 4'b0010, '0);
    check("intr_back_to_run", 32'(state), 1);
    check("intr_no_done", 32'(done), 0);
    cycle(1'b0, '0, 4'b0010);
    run_until_done(50, nb);
    check("intr_redrain", nb, DRAIN_CYCLES + 1);

    // Watchdog with an objection held
    wdog_limit = 16'd10;
    cycle(1'b1, 4'b1000, '0);
    run_until_done(50, nb);
    check("wdog_busy_cycles", nb, 10);
    check("wdog_timeout", 32'(timeout), 1);
    cycle(1'b0, '0, 4'b1000);

    // Watchdog expiry on the same cycle as drain completion
    wdog_limit = 16'(DRAIN_CYCLES + 1);
    cycle(1'b1, '0, '0);
    run_until_done(50, nb);
    check("tie_busy_cycles", nb, DRAIN_CYCLES + 1);
    check("tie_timeout", 32'(timeout), 1);
    wdog_limit = '0;

    // Error flags
    cycle(1'b0, '0, 4'b0001);
    check("unf_flag", 32'(underflow_err), 32'h1);
    repeat (4) cycle(1'b0, 4'b0010, '0);
    check("ovf_flag", 32'(overflow_err), 32'h2);
    check("ovf_saturated", 32'(total), CNT_MAX);
    repeat (CNT_MAX) cycle(1'b0, '0, 4'b0010);
    cycle(1'b1, '0, '0);
    check("start_clears_unf", 32'(underflow_err), 0);
    check("start_clears_ovf", 32'(overflow_err), 0);
    run_until_done(50, nb);

    // Reset in DRAIN with an error flag set
    cycle(1'b1, '0, '0);
    cycle(1'b0, '0, 4'b0100);
    cycle(1'b0, '0, '0);
    check("pre_rst_drain", 32'(state), 2);
    async_reset();
    cycle(1'b0, '0, '0);
    cycle(1'b1, '0, '0);
    run_until_done(50, nb);
    check("post_rst_busy_cycles", nb, DRAIN_CYCLES + 1);

    // Random objection traffic, sometimes with a watchdog, one run reset mid-way
    for (int run = 0; run < 14; run++) begin
      wdog_limit = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(3, 40)) : 16'd0;
      cycle(1'b1, '0, '0);
      for (int k = 0; k < 40; k++) begin
        r = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        d = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        cycle(($urandom_range(0, 15) == 0), r, d);
        if (run == 5 && k == 20) async_reset();
      end
      repeat (CNT_MAX + 1) cycle(1'b0, '0, '1);
      cycle(1'b1, '0, '0);
      run_until_done(100, nb);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout sim time expired, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule

// File: doc/googletest_objection_ctrl.md
# googletest_objection_ctrl

Synthesizable end-of-test controller for HDL benches driven by the googletest runner. It tracks raise/drop objections from up to NUM_REQ bench agents (BFMs, scoreboards) and sequences the run: start, wait for objections, drain, and done or timeout. Its `done`/`timeout` outputs are what the top-level test task polls before reporting PASSED/FAILED and calling `$finish`.

## Interface
Parameters:
- NUM_REQ, 4, number of objection requesters (1..16)
- CNT_W, 8, width of each per-requester objection counter
- DRAIN_CYCLES, 16, consecutive zero-objection cycles required before done (>=1)
- WDOG_W, 32, watchdog counter width

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a run from IDLE or DONE
- raise  in  NUM_REQ  per-requester raise-one-objection pulse
- drop  in  NUM_REQ  per-requester drop-one-objection pulse
- wdog_limit  in  WDOG_W  run-length limit in cycles; 0 disables the watchdog
- total  out  CNT_W+$clog2(NUM_REQ)+1  sum of all per-requester counters
- busy  out  1  high in RUN or DRAIN
- done  out  1  level; high in DONE
- timeout  out  1  level; high in DONE when the run ended by watchdog
- underflow_err  out  NUM_REQ  sticky; a drop arrived with that counter at 0
- overflow_err  out  NUM_REQ  sticky; a raise arrived with that counter at max
- state  out  2  current FSM state, for debug

## Operation
- Per-requester counter, always active, including in IDLE and DONE:
  - raise and drop in the same cycle: no change.
  - raise alone: +1. At 2^CNT_W-1 the counter saturates and sets overflow_err[i].
  - drop alone: -1. At 0 the counter stays at 0 and sets underflow_err[i].
- `total` is a combinational sum of the registered counters. "Quiet" means total==0 and raise==0 in the current cycle.
- FSM states: IDLE=0, RUN=1, DRAIN=2, DONE=3.
  - IDLE: on start, go to RUN. Clear wdog_cnt, timeout, underflow_err and overflow_err.
  - RUN: if quiet, go to DRAIN with drain_cnt=0. Otherwise stay in RUN.
  - DRAIN: if not quiet, go back to RUN. If quiet and drain_cnt==DRAIN_CYCLES-1, go to DONE. Otherwise increment drain_cnt.
  - DONE: hold. On start, same action as start from IDLE.
- start in RUN or DRAIN is ignored.
- Watchdog:
  - wdog_cnt increments every cycle in RUN or DRAIN.
  - If wdog_limit!=0 and wdog_cnt==wdog_limit-1, go to DONE next edge with timeout=1.
  - If watchdog expiry and drain completion fall in the same cycle, timeout wins: timeout=1.
- Sticky error bits clear only on start or reset.
- Reset may arrive mid-operation. It asynchronously forces IDLE, zeroes all counters, and drives every output to 0. total is 0 after reset.

## Timing
- A counter change is visible on `total` in the cycle after the raise/drop edge.
- start sampled at edge k: busy=1 from k+1.
- Minimum run with no objections: RUN for 1 cycle, then DRAIN for DRAIN_CYCLES cycles. done rises DRAIN_CYCLES+1 cycles after busy rises.
- A raise in any DRAIN cycle, including the last, prevents DONE. The FSM re-enters RUN next edge and the drain restarts from 0 on the next quiet cycle.
- timeout/done rise exactly wdog_limit cycles after busy rises, unless the run completes earlier.
- done and busy are never high together.

## Structure
- Shared package googletest_hdl_pkg holds:
  - typedef enum logic [1:0] objctl_state_e {IDLE, RUN, DRAIN, DONE}
  - localparam OBJCTL_STATE_W=2
- Sub-module googletest_objection_counter: one saturating up/down counter with underflow/overflow sticky flags, instantiated NUM_REQ times in a generate loop.
- The top level contains the FSM, drain counter, watchdog and adder tree.

## Test plan
- Empty run: DRAIN_CYCLES=4, start with no raises. Expect busy for 5 cycles, then done=1, timeout=0, total=0.
- Normal run: raise[0] x2, raise[2] x1, then drops spaced over 20 cycles. Expect total to go 1,2,3 then back down to 0. done asserts exactly 4 cycles after the first quiet DRAIN entry.
- Drain interrupt: raise[1] on the last DRAIN cycle. Expect state to return to RUN (1), no done. After the matching drop, expect a full 4-cycle drain again, then done.
- Watchdog: wdog_limit=10, raise[3] held with no drop. Expect done=1 and timeout=1 exactly 10 cycles after start. Repeat with drain completion on the same cycle and expect timeout=1.
- Error flags: drop[0] at count 0 sets underflow_err=4'b0001 and the count stays 0. CNT_W=2 with 4 raises on requester 1 sets overflow_err[1] and the counter stays at 3. A new start clears both.
- Reset mid-run: assert rst_n=0 during DRAIN. Expect an immediate async return to state=0, busy=0, total=0, all errors 0. After release, start behaves as the empty-run case.
